// File: rtl/adder_sweep_pkg.sv
// adder_sweep_pkg: shared state type, default width and last-index helper for the operand sweep
package adder_sweep_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int WIDTH_DEF = 4;
  function automatic int last_idx(input int w);
    return (1 << (2 * w + 1)) - 1;
  endfunction
endpackage

// File: rtl/adder_ref_check.sv
// adder_ref_check: compares the adder result against a reference sum on each transfer and counts mismatches
module adder_ref_check #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           cin,
  input  logic [W-1:0]   s_in,
  input  logic           cout_in,
  input  logic           xfer,
  input  logic           clr,
  output logic [2*W+1:0] err_cnt
);
  logic [W:0]     exp_sum;
  logic [2*W+1:0] err_d, err_q;
  assign exp_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign err_cnt = err_q;
  // clear on an accepted start, otherwise count one per mismatching transfer
  always_comb begin
    err_d = clr ? '0 : (xfer && ({cout_in, s_in} != exp_sum)) ? err_q + 1'b1 : err_q;
  end
  // error counter register
  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end
endmodule

// File: rtl/adder_sweep_gen.sv
// adder_sweep_gen: exhaustive {cin,a,b} operand generator with valid/ready handshake; ADDER_SWEEP_SELF_CHECK_EN adds result checking
module adder_sweep_gen
  import adder_sweep_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk_50MHz,
  input  logic               rst,
  input  logic               start,
  input  logic               op_ready,
`ifdef ADDER_SWEEP_SELF_CHECK_EN
  input  logic [WIDTH-1:0]   s_in,
  input  logic               cout_in,
  output logic [2*WIDTH+1:0] err_cnt,
`endif
  output logic               op_valid,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic               cin,
  output logic [2*WIDTH:0]   vec_idx,
  output logic               busy,
  output logic               done
);
  localparam int IW = 2 * WIDTH + 1;
  localparam logic [IW-1:0] LAST = IW'(last_idx(WIDTH));
  state_t        state_d, state_q;
  logic [IW-1:0] idx_d, idx_q;
  logic          xfer, start_acc;
  assign op_valid  = (state_q == RUN);
  assign busy      = op_valid;
  assign done      = (state_q == DONE);
  assign xfer      = op_valid && op_ready;
  assign start_acc = start && (state_q != RUN);
  assign vec_idx   = idx_q;
  assign b         = idx_q[WIDTH-1:0];
  assign a         = idx_q[2*WIDTH-1:WIDTH];
  assign cin       = idx_q[2*WIDTH];
  // start restarts from zero outside RUN; each transfer advances, the last one finishes and holds the index
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (start_acc) begin
      state_d = RUN;
      idx_d   = '0;
    end else if (xfer) begin
      state_d = (idx_q == LAST) ? DONE : RUN;
      idx_d   = (idx_q == LAST) ? idx_q : idx_q + 1'b1;
    end
  end
  // state and index registers
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end
`ifdef ADDER_SWEEP_SELF_CHECK_EN
  adder_ref_check #(.W(WIDTH)) u_chk (
    .clk     (clk_50MHz),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .s_in    (s_in),
    .cout_in (cout_in),
    .xfer    (xfer),
    .clr     (start_acc),
    .err_cnt (err_cnt)
  );
`endif
endmodule

// File: tb/tb_adder_sweep_gen.sv
// tb_adder_sweep_gen: scoreboard bench for the operand sweep generator
module tb_adder_sweep_gen;
  logic       clk = 0, rst = 1, start = 1, op_ready = 1;
  logic       op_valid, cin, busy, done;
  logic [3:0] a, b;
  logic [8:0] vec_idx;
  int         total = 0, bad = 0;
  logic [8:0] q[$];
`ifdef ADDER_SWEEP_SELF_CHECK_EN
  logic [3:0] s_in;
  logic       cout_in, bad_adder = 0;
  logic [9:0] err_cnt;
  assign {cout_in, s_in} = bad_adder ? 5'd0 : {1'b0, a} + {1'b0, b} + {4'd0, cin};
`endif

  adder_sweep_gen #(.WIDTH(4)) dut (
    .clk_50MHz (clk),
    .rst       (rst),
    .start     (start),
    .op_ready  (op_ready),
`ifdef ADDER_SWEEP_SELF_CHECK_EN
    .s_in      (s_in),
    .cout_in   (cout_in),
    .err_cnt   (err_cnt),
`endif
    .op_valid  (op_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .vec_idx   (vec_idx),
    .busy      (busy),
    .done      (done)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) q.push_back(9'(i));
  endtask

  task automatic pulse_start;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_vec(input int v);
    int n = 0;
    while (vec_idx != 9'(v) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_vec", vec_idx, v);
  endtask

  task automatic check_zero(input string name);
    chk(name, {op_valid, busy, done, cin, a, b, vec_idx}, 0);
  endtask

  // monitor: every transfer pops the next expected index and checks index and operand slices
  always @(negedge clk) begin
    logic [8:0] e;
    if (op_valid && op_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_xfer: got vec %0d expected none", vec_idx);
      end else begin
        e = q.pop_front();
        chk("xfer_vec", vec_idx, e);
        chk("xfer_abc", {cin, a, b}, {e[8], e[7:4], e[3:0]});
      end
    end
  end

  initial begin
    int n;
    repeat (3) begin
      @(negedge clk);
      check_zero("reset_hold");
    end
    @(posedge clk); #1 rst = 0; start = 0;
    @(posedge clk); #1;
    check_zero("idle_after_reset");

    push_range(0, 511);
    pulse_start;
    chk("first_vec", vec_idx, 0);
    chk("first_busy", {op_valid, busy, done}, 3'b110);
    n = 1;
    while (busy && n < 600) begin
      @(posedge clk); #1;
      if (busy) n++;
      start = (vec_idx == 9'd50 || vec_idx == 9'd300);
      if (vec_idx == 9'd16) chk("a_b_cin_at16", {cin, a, b}, 9'b0_0001_0000);
      if (vec_idx == 9'd256) chk("a_b_cin_at256", {cin, a, b}, 9'b1_0000_0000);
    end
    start = 0;
    chk("sweep_cycles", n, 512);
    chk("end_flags", {op_valid, busy, done}, 3'b001);
    chk("end_vec", vec_idx, 511);
`ifdef ADDER_SWEEP_SELF_CHECK_EN
    chk("err_good_adder", err_cnt, 0);
`endif
    chk("q_empty_1", q.size(), 0);

    push_range(0, 100);
    pulse_start;
    chk("restart_from_done", {op_valid, busy, done, vec_idx}, {3'b110, 9'd0});
    wait_vec(37);
    op_ready = 0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_hold", {op_valid, cin, a, b, vec_idx}, {1'b1, 1'b0, 4'd2, 4'd5, 9'd37});
    end
    op_ready = 1;
    @(posedge clk); #1;
    chk("bp_next", {b, vec_idx}, {4'd6, 9'd38});
    wait_vec(100);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    check_zero("mid_run_reset");
    @(posedge clk); #1;
    check_zero("idle_after_mid_reset");
    chk("q_empty_2", q.size(), 0);

`ifdef ADDER_SWEEP_SELF_CHECK_EN
    bad_adder = 1;
`endif
    push_range(0, 511);
    pulse_start;
    chk("restart_after_reset", {busy, vec_idx}, {1'b1, 9'd0});
    n = 0;
    while (!done && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_2", {op_valid, busy, done, vec_idx}, {3'b001, 9'd511});
`ifdef ADDER_SWEEP_SELF_CHECK_EN
    chk("err_bad_adder", err_cnt, 511);
`endif
    chk("q_empty_3", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_sweep_gen.md
Name: adder_sweep_gen

Overview:
- Synthesizable upstream operand generator for adder_4bit. Feeds A/B/Cin directly.
- Sweeps the full operand space in hardware: b fastest, then a, then cin. This is the team's standard exhaustive order.
- Uses a valid/ready handshake so a registered or slower consumer can backpressure it.
- Optional on-chip self-check compares the adder's result against a reference sum.

Parameters:
- WIDTH, 4, operand width of a and b.

Ports:
- clk_50MHz  input  1  system clock, 50 MHz
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a sweep from IDLE or DONE
- op_ready  input  1  consumer accepts the current vector
- op_valid  output  1  current a/b/cin vector is valid
- a  output  WIDTH  operand A
- b  output  WIDTH  operand B
- cin  output  1  carry-in
- vec_idx  output  2*WIDTH+1  current vector index, equal to {cin,a,b}
- busy  output  1  high while in RUN
- done  output  1  sticky sweep-complete flag; cleared by start or rst
- s_in  input  WIDTH  adder sum (SELF_CHECK_EN only)
- cout_in  input  1  adder carry-out (SELF_CHECK_EN only)
- err_cnt  output  2*WIDTH+2  mismatch count (SELF_CHECK_EN only)

Behaviour:
- Clock and reset: single clock clk_50MHz. rst is synchronous, active-high, and overrides everything else.
- Reset values: state=IDLE; op_valid, busy, done = 0; a, b, cin, vec_idx = 0; err_cnt = 0.
- States and transitions:
  - IDLE: start=1 -> RUN on the next edge. vec_idx=0, op_valid=1, busy=1, done=0 are visible the cycle after start (1-cycle latency).
  - RUN, transfer (op_valid && op_ready at an edge), vec_idx != LAST: vec_idx increments.
  - RUN, transfer, vec_idx == LAST (2^(2W+1)-1, i.e. 511 at W=4): -> DONE at that edge. op_valid=0, busy=0, done=1. vec_idx holds LAST.
  - DONE: start=1 -> RUN exactly as from IDLE. vec_idx restarts at 0 and done clears.
- Output mapping: a, b and cin are direct slices of vec_idx: b = vec_idx[W-1:0], a = vec_idx[2W-1:W], cin = vec_idx[2W].
- Wrap-around: b wraps 15->0 and carries into a; a wraps 15->0 and carries into cin. No other wrap exists; the sweep ends at LAST.
- Backpressure: while op_valid=1 and op_ready=0, a/b/cin/vec_idx hold exactly. op_valid never drops before a transfer.
- start during RUN: ignored; no restart, no glitch.
- start and rst in the same cycle: rst wins.
- Reset mid-operation: next cycle matches the reset values; no partial state is retained.
- op_ready while op_valid=0: ignored.

Optional Feature:
- Macro: ADDER_SWEEP_SELF_CHECK_EN.
- Defined:
  - s_in, cout_in and err_cnt exist.
  - On every transfer edge, expected = a+b+cin at WIDTH+1 bits; {cout_in,s_in} is compared against it. The adder is combinational, so the result is sampled at the same edge.
  - A mismatch increments err_cnt. err_cnt cannot overflow: max 2^(2W+1) errors fit in 2W+2 bits.
  - err_cnt clears on rst and on an accepted start.
- Undefined: those three ports are absent and no check logic is generated.

Decomposition:
- Package adder_sweep_pkg:
  - state enum {IDLE, RUN, DONE}
  - default WIDTH constant
  - LAST_IDX computation as a constant function of WIDTH
- Sub-module adder_ref_check, instantiated only under ADDER_SWEEP_SELF_CHECK_EN:
  - holds the expected-sum compare and err_cnt register
  - inputs: a, b, cin, s_in, cout_in, transfer strobe, clear
- The FSM and index counter stay in adder_sweep_gen.

Test Plan:
- Reset: rst=1 for 3 cycles with start=1 and op_ready=1 -> all outputs 0, state IDLE throughout; no sweep begins.
- Full sweep: start pulse, op_ready tied 1 -> vectors 0..511 on 512 consecutive cycles:
  - transfer 16 shows a=1, b=0, cin=0
  - transfer 256 shows a=0, b=0, cin=1
  - the edge after vector 511 gives busy=0, done=1, op_valid=0
- Backpressure: drop op_ready for 5 cycles while vec_idx=37 -> a=2, b=5, cin=0 held all 5 cycles. Next transfer yields vec_idx=38 (b=6).
- Reset mid-run: assert rst at vec_idx=100 -> next cycle all outputs 0, IDLE. A later start restarts at vec_idx=0.
- Start handling:
  - start pulses at vec_idx=50 and 300 -> ignored, sweep continues.
  - start in DONE -> done clears, new sweep from 0.
- Self-check (macro defined):
  - s_in/cout_in driven by a correct adder -> err_cnt=0 at done.
  - s_in and cout_in forced to 0 -> err_cnt=511 at done. Only a=0, b=0, cin=0 has expected {cout,s}=0.
